// File: rtl/accu_split_pkg.sv
// Shared definitions for the accumulation path: default widths, state encoding
// and the largest total a burst can represent without wrapping.
package accu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int N_DEF      = 8;

  typedef enum logic {IDLE, EMIT} state_t;

  function automatic int sum_w(input int data_w, input int n);
    return data_w + $clog2(n);
  endfunction

  function automatic int max_total(input int data_w, input int n);
    return n * ((1 << data_w) - 1);
  endfunction

  localparam int MAX_TOTAL = max_total(DATA_W_DEF, N_DEF);

endpackage

// File: rtl/accu_split_if.sv
// Total-in / sample-burst-out stream bundle for accu_split.
// ACCU_SPLIT_SAT_EN adds the sat_out clamp indicator.
interface accu_split_if #(
  parameter int DATA_W = accu_pkg::DATA_W_DEF,
  parameter int SUM_W  = accu_pkg::sum_w(accu_pkg::DATA_W_DEF, accu_pkg::N_DEF)
);

  logic [SUM_W-1:0]  data_in;
  logic              valid_in;
  logic              ready_out;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              last_out;
`ifdef ACCU_SPLIT_SAT_EN
  logic              sat_out;

  modport master (output data_in, valid_in,
                  input  ready_out, data_out, valid_out, last_out, sat_out);
  modport slave  (input  data_in, valid_in,
                  output ready_out, data_out, valid_out, last_out, sat_out);
`else
  modport master (output data_in, valid_in,
                  input  ready_out, data_out, valid_out, last_out);
  modport slave  (input  data_in, valid_in,
                  output ready_out, data_out, valid_out, last_out);
`endif

endinterface

// File: rtl/accu_split.sv
// Splits one wide total into a burst of N near-equal narrow samples summing to it.
// Define ACCU_SPLIT_SAT_EN to clamp oversized totals and pulse sat_out.
module accu_split
  import accu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N      = N_DEF,
  parameter int SUM_W  = sum_w(DATA_W, N)
) (
  input  logic         clk,
  input  logic         rst_n,
  accu_split_if.slave  bus
);

  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] q;
  logic [CNT_W-1:0]  r;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              last_q;

  logic              ready;
  logic              accept;
  logic [SUM_W-1:0]  total;
  logic [DATA_W-1:0] new_q;
  logic [CNT_W-1:0]  new_r;
  logic [CNT_W-1:0]  cnt_nxt;

  // The first r beats of a burst carry the remainder; q+1 wraps for oversized totals.
  function automatic logic [DATA_W-1:0] beat_value(input logic [DATA_W-1:0] qv,
                                                   input logic [CNT_W-1:0]  rv,
                                                   input logic [CNT_W-1:0]  idx);
    return (idx < rv) ? qv + DATA_W'(1) : qv;
  endfunction

`ifdef ACCU_SPLIT_SAT_EN
  localparam logic [SUM_W-1:0] MAX_TOTAL_P = SUM_W'(max_total(DATA_W, N));
  logic clamp;
  logic sat_q;

  assign clamp       = bus.data_in > MAX_TOTAL_P;
  assign total       = clamp ? MAX_TOTAL_P : bus.data_in;
  assign bus.sat_out = sat_q;
`else
  assign total = bus.data_in;
`endif

  assign ready   = (state == IDLE) || (state == EMIT && cnt == LAST_BEAT);
  assign accept  = bus.valid_in && ready;
  assign new_q   = total[SUM_W-1:CNT_W];
  assign new_r   = total[CNT_W-1:0];
  assign cnt_nxt = cnt + CNT_W'(1);

  assign bus.ready_out = ready;
  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.last_out  = last_q;

  // Outputs are registered one beat ahead so a new total shows its first sample
  // in the cycle right after it is accepted, even back-to-back with a prior burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      q       <= '0;
      r       <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
`ifdef ACCU_SPLIT_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
`ifdef ACCU_SPLIT_SAT_EN
      sat_q <= accept && clamp;
`endif
      if (accept) begin
        state   <= EMIT;
        q       <= new_q;
        r       <= new_r;
        cnt     <= '0;
        data_q  <= beat_value(new_q, new_r, '0);
        valid_q <= 1'b1;
        last_q  <= (LAST_BEAT == '0);
      end else if (state == EMIT) begin
        if (cnt == LAST_BEAT) begin
          state   <= IDLE;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
        end else begin
          cnt    <= cnt_nxt;
          data_q <= beat_value(q, r, cnt_nxt);
          last_q <= (cnt_nxt == LAST_BEAT);
        end
      end
    end
  end

endmodule
